// File: rtl/alu_op_enum.sv
// ALU control encodings shared by the decoder, immediate generator and execute stage.
// Holds compare/op/operand-select enums, opcode constants and the decoded bundle.
package alu_op_enum;

    typedef enum logic [2:0] {
        ALU_COMP_NONE = 3'd0,
        ALU_COMP_BEQ  = 3'd1,
        ALU_COMP_BNE  = 3'd2,
        ALU_COMP_BLT  = 3'd3,
        ALU_COMP_BGE  = 3'd4,
        ALU_COMP_BLTU = 3'd5,
        ALU_COMP_BGEU = 3'd6
    } alu_comp_e;

    // Encoding mirrors RV32I funct3 so OP/OP-IMM map directly.
    typedef enum logic [2:0] {
        ALU_OP_1_ADD  = 3'd0,
        ALU_OP_1_SLL  = 3'd1,
        ALU_OP_1_SLT  = 3'd2,
        ALU_OP_1_SLTU = 3'd3,
        ALU_OP_1_XOR  = 3'd4,
        ALU_OP_1_SRL  = 3'd5,
        ALU_OP_1_OR   = 3'd6,
        ALU_OP_1_AND  = 3'd7
    } alu_op_1_e;

    typedef enum logic [1:0] {
        ALU_A_SEL_RS1  = 2'd0,
        ALU_A_SEL_PC   = 2'd1,
        ALU_A_SEL_ZERO = 2'd2
    } alu_a_sel_e;

    typedef enum logic {
        ALU_B_SEL_RS2 = 1'b0,
        ALU_B_SEL_IMM = 1'b1
    } alu_b_sel_e;

    typedef enum logic [2:0] {
        IMM_FMT_NONE = 3'd0,
        IMM_FMT_I    = 3'd1,
        IMM_FMT_S    = 3'd2,
        IMM_FMT_B    = 3'd3,
        IMM_FMT_U    = 3'd4
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_comp_e   comp_sel;
        logic        op_0;
        alu_op_1_e   op_1;
        alu_a_sel_e  a_sel;
        alu_b_sel_e  b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wr_en;
        logic        illegal;
    } alu_ctl_t;

    function automatic alu_comp_e f3_to_comp(input logic [2:0] f3);
        alu_comp_e c;
        unique case (f3)
            3'b000:  c = ALU_COMP_BEQ;
            3'b001:  c = ALU_COMP_BNE;
            3'b100:  c = ALU_COMP_BLT;
            3'b101:  c = ALU_COMP_BGE;
            3'b110:  c = ALU_COMP_BLTU;
            3'b111:  c = ALU_COMP_BGEU;
            default: c = ALU_COMP_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_imm_gen.sv
// Combinational RV32I immediate extraction and sign extension.
// Ports: inst_i (word), imm_o (32-bit immediate), fmt_o (imm_fmt_e encoding).
module alu_imm_gen
    import alu_op_enum::*;
(
    input  logic [31:0] inst_i,
    output logic [31:0] imm_o,
    output logic [2:0]  fmt_o
);

    always_comb begin
        imm_o = '0;
        fmt_o = IMM_FMT_NONE;
        unique case (inst_i[6:0])
            OPC_OP_IMM, OPC_LOAD: begin
                fmt_o = IMM_FMT_I;
                imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            OPC_STORE: begin
                fmt_o = IMM_FMT_S;
                imm_o = {{20{inst_i[31]}}, inst_i[31:25],
                         inst_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = IMM_FMT_B;
                imm_o = {{20{inst_i[31]}}, inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = IMM_FMT_U;
                imm_o = {inst_i[31:12], 12'b0};
            end
            default: begin
                fmt_o = IMM_FMT_NONE;
                imm_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctl.sv
// RV32I decode stage: one-entry registered ALU control toward execute.
// Ports: inst valid/ready/data in, out valid/ready, flush_i, ALU selects,
// imm/rs1/rs2/rd, rd_wr_en_o, illegal_o. Macro ALU_CTL_ILLEGAL_CHK_EN
// flags illegal words; otherwise they decode as ADDI x0,x0,0.
module alu_ctl
    import alu_op_enum::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        inst_valid_i,
    output logic        inst_ready_o,
    input  logic [31:0] inst_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    input  logic        flush_i,
    output logic [2:0]  alu_comp_sel_o,
    output logic        alu_op_0_sel_o,
    output logic [2:0]  alu_op_1_sel_o,
    output logic [1:0]  alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic [31:0] imm_data_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wr_en_o,
    output logic        illegal_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        bad;
    logic        shift;
    logic        accept;
    logic        out_valid_q;
    alu_ctl_t    dec;
    alu_ctl_t    q;

    assign opc = inst_data_i[6:0];
    assign f3  = inst_data_i[14:12];
    assign f7  = inst_data_i[31:25];
    assign shift = (f3 == 3'b001) || (f3 == 3'b101);

    alu_imm_gen u_imm_gen (
        .inst_i (inst_data_i),
        .imm_o  (imm),
        .fmt_o  (fmt)
    );

    always_comb begin
        dec          = '0;
        dec.comp_sel = ALU_COMP_NONE;
        dec.op_1     = ALU_OP_1_ADD;
        dec.a_sel    = ALU_A_SEL_RS1;
        // Any I/S/U immediate feeds operand B; branches compare RS2.
        dec.b_sel    = (fmt == IMM_FMT_I || fmt == IMM_FMT_S ||
                        fmt == IMM_FMT_U) ? ALU_B_SEL_IMM
                                          : ALU_B_SEL_RS2;
        dec.imm      = imm;
        dec.rs1      = inst_data_i[19:15];
        dec.rs2      = inst_data_i[24:20];
        dec.rd       = inst_data_i[11:7];
        bad          = 1'b0;
        unique case (1'b1)
            (opc == OPC_OP): begin
                dec.op_1     = alu_op_1_e'(f3);
                dec.op_0     = f7[5];
                dec.rd_wr_en = 1'b1;
                bad = !((f7 == F7_BASE) ||
                        ((f7 == F7_ALT) &&
                         (f3 == 3'b000 || f3 == 3'b101)));
            end
            (opc == OPC_OP_IMM): begin
                dec.op_1     = alu_op_1_e'(f3);
                dec.op_0     = (f3 == 3'b101) && f7[5];
                dec.rd_wr_en = 1'b1;
                // Only shifts reuse funct7; SLLI has no alt form.
                if (shift) begin
                    bad = !((f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && (f3 == 3'b101)));
                end
            end
            (opc == OPC_BRANCH): begin
                dec.comp_sel = f3_to_comp(f3);
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            (opc == OPC_LUI): begin
                dec.a_sel    = ALU_A_SEL_ZERO;
                dec.rd_wr_en = 1'b1;
            end
            (opc == OPC_AUIPC): begin
                dec.a_sel    = ALU_A_SEL_PC;
                dec.rd_wr_en = 1'b1;
            end
            (opc == OPC_LOAD): begin
                dec.rd_wr_en = 1'b1;
            end
            (opc == OPC_STORE): begin
                dec.rd_wr_en = 1'b0;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        if (dec.rd == 5'd0) begin
            dec.rd_wr_en = 1'b0;
        end
`ifdef ALU_CTL_ILLEGAL_CHK_EN
        dec.illegal = bad;
        if (bad) begin
            dec.rd_wr_en = 1'b0;
        end
`else
        // Illegal words become a harmless ADDI x0,x0,0.
        if (bad) begin
            dec       = '0;
            dec.b_sel = ALU_B_SEL_IMM;
        end
`endif
    end

    assign inst_ready_o = !flush_i && (!out_valid_q || out_ready_i);
    assign accept       = inst_valid_i && inst_ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            q           <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            q           <= dec;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign alu_comp_sel_o = q.comp_sel;
    assign alu_op_0_sel_o = q.op_0;
    assign alu_op_1_sel_o = q.op_1;
    assign alu_a_sel_o    = q.a_sel;
    assign alu_b_sel_o    = q.b_sel;
    assign imm_data_o     = q.imm;
    assign rs1_addr_o     = q.rs1;
    assign rs2_addr_o     = q.rs2;
    assign rd_addr_o      = q.rd;
    assign rd_wr_en_o     = q.rd_wr_en;
    assign illegal_o      = q.illegal;

endmodule
